// File: rtl/flash_arb_pkg.sv
// Shared types and defaults for the two-requester flash read arbiter.
package flash_arb_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 31;

    typedef enum logic [1:0] {
        StIdle,
        StDiscard,
        StCapture,
        StResp
    } arb_state_t;

    // Timer width able to hold 0..timeout, never narrower than one bit.
    function automatic int unsigned timer_width(input int unsigned timeout);
        int unsigned w;
        w = $clog2(timeout + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/flash_rr_select.sv
// Two-way round-robin picker: on a tie the requester not served last wins.
module flash_rr_select (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_id,
    output logic gnt_valid
);

    always_comb begin
        gnt_valid = req0 | req1;
        gnt_id    = 1'b0;
        if (req0 && req1) begin
            gnt_id = ~last;
        end else if (req1) begin
            gnt_id = 1'b1;
        end
    end

endmodule

// File: rtl/flash_arbiter.sv
// Arbitrates two read requesters onto a free-running flash reader, discarding the
// first ready pulse after each grant because it may carry the previous address.
module flash_arbiter
    import flash_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [22:1] addr0,
    input  logic        req1,
    input  logic [22:1] addr1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata,
    output logic        err,
    output logic [22:1] fl_addr,
    input  logic [15:0] fl_data,
    input  logic        fl_ready
);

    localparam int unsigned TimerW = timer_width(TIMEOUT);
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT);

    arb_state_t        state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic [22:1]       addr_q, addr_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic sel_id;
    logic sel_valid;

    flash_rr_select u_rr (
        .req0      (req0),
        .req1      (req1),
        .last      (last_q),
        .gnt_id    (sel_id),
        .gnt_valid (sel_valid)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                // fl_ready is deliberately ignored here.
                if (sel_valid) begin
                    gnt_d   = sel_id;
                    addr_d  = sel_id ? addr1 : addr0;
                    timer_d = '0;
                    state_d = StDiscard;
                end
            end
            StDiscard: begin
                if (fl_ready) begin
                    timer_d = '0;
                    state_d = StCapture;
                end else if (timer_q == TimerMax) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StCapture: begin
                if (fl_ready) begin
                    rdata_d = fl_data;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (timer_q == TimerMax) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StResp: begin
                last_d  = gnt_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            timer_q <= '0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Acks decode straight from registered state, so they are one cycle and exclusive.
    assign ack0    = (state_q == StResp) && !gnt_q;
    assign ack1    = (state_q == StResp) && gnt_q;
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign fl_addr = addr_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Scoreboard bench for flash_arbiter with a 6-cycle free-running reader model.
module tb_flash_arbiter;

    localparam int unsigned TIMEOUT = 31;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [22:1] addr0, addr1;
    logic        ack0, ack1;
    logic [15:0] rdata;
    logic        err;
    logic [22:1] fl_addr;
    logic [15:0] fl_data;
    logic        fl_ready;

    flash_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .addr0    (addr0),
        .req1     (req1),
        .addr1    (addr1),
        .ack0     (ack0),
        .ack1     (ack1),
        .rdata    (rdata),
        .err      (err),
        .fl_addr  (fl_addr),
        .fl_data  (fl_data),
        .fl_ready (fl_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        id;
        logic [15:0] data;
        logic        err;
        logic [22:1] addr;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lc = 0;
    bit          reader_en = 1'b1;
    bit          last_srv = 1'b1;
    logic [22:1] sampled;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input bit id, input logic [22:1] a, input bit en);
        exp_t e;
        e.id   = id;
        e.addr = a;
        e.err  = !en;
        e.data = en ? a[16:1] : 16'h0000;
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reader: samples fl_addr entering loop cycle 3, pulses ready in loop cycle 4.
    initial begin
        fl_ready = 1'b0;
        fl_data  = '0;
        sampled  = '0;
        forever begin
            @(negedge clk);
            lc = (lc + 1) % 6;
            if (lc == 3) sampled = fl_addr;
            fl_ready = reader_en && (lc == 4);
            fl_data  = fl_ready ? sampled[16:1] : 16'($urandom);
        end
    end

    // Monitor: pops one expected response per ack.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && (ack0 || ack1)) begin
            check("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack actual=ack0:%0b/ack1:%0b required=none", ack0, ack1);
            end else begin
                e = exp_q.pop_front();
                check("ack_id", {31'd0, ack1}, {31'd0, e.id});
                check("rdata", {16'd0, rdata}, {16'd0, e.data});
                check("err", {31'd0, err}, {31'd0, e.err});
                check("fl_addr_at_ack", {10'd0, fl_addr}, {10'd0, e.addr});
            end
        end
    end

    // Called at a negedge with the arbiter idle; returns at a negedge with it idle again.
    task automatic do_round(input bit r0, input bit r1, input logic [22:1] a0,
                            input logic [22:1] a1, input bit rep, input logic [22:1] a_rep,
                            input bit en, input int align);
        int  n, g, j1, ack_cyc, exp_cyc;
        bit  reps_left, stable, lone, w;
        logic [22:1] a_lone;
        #1;
        if (align >= 0) begin
            while (lc != align) begin
                @(negedge clk);
                #1;
            end
        end
        reader_en = en;
        lone      = !(r0 && r1);
        a_lone    = r1 ? a1 : a0;
        if (!lone) begin
            w = ~last_srv;
            exp_q.push_back(mk(w, w ? a1 : a0, 1'b1));
            exp_q.push_back(mk(~w, w ? a0 : a1, 1'b1));
            last_srv = ~w;
        end else begin
            exp_q.push_back(mk(r1, a_lone, en));
            if (rep) exp_q.push_back(mk(r1, a_rep, en));
            last_srv = r1;
        end
        g  = cyc + 1;
        j1 = 6;
        for (int j = 1; j <= 6; j++) begin
            if ((lc + j) % 6 == 4) begin
                j1 = j;
                break;
            end
        end
        exp_cyc   = en ? (g + j1 + 6) : (g + TIMEOUT + 1);
        ack_cyc   = -1;
        reps_left = rep;
        stable    = 1'b1;
        addr0 = a0;
        addr1 = a1;
        req0  = r0;
        req1  = r1;
        n = 0;
        while ((req0 || req1) && n < 200) begin
            @(negedge clk);
            n++;
            if (lone && ack_cyc < 0 && fl_addr !== a_lone) stable = 1'b0;
            if (ack0 || ack1) begin
                if (ack_cyc < 0) ack_cyc = cyc;
                if (reps_left) begin
                    reps_left = 1'b0;
                    if (ack0) addr0 = a_rep;
                    else      addr1 = a_rep;
                end else begin
                    if (ack0) req0 = 1'b0;
                    if (ack1) req1 = 1'b0;
                end
            end
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL round_timeout actual=no_ack required=ack_within_200");
            req0 = 1'b0;
            req1 = 1'b0;
        end
        #1;
        check("first_ack_cycle", ack_cyc, exp_cyc);
        if (lone) check("fl_addr_stable", {31'd0, stable}, 32'd1);
        check("queue_drained", exp_q.size(), 32'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        int n;
        bit saw_ack;
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int          pat, n;
        bit          rep, en, saw_ack;
        logic [22:1] ra0, ra1, rr;
        rst   = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        addr0 = '0;
        addr1 = '0;
        repeat (3) @(negedge clk);
        check("rst_ack0", {31'd0, ack0}, 32'd0);
        check("rst_ack1", {31'd0, ack1}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", {16'd0, rdata}, 32'd0);
        check("rst_fl_addr", {10'd0, fl_addr}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);

        // Single read
        do_round(1'b1, 1'b0, 22'h000010, 22'h0, 1'b0, 22'h0, 1'b1, -1);

        // Reset while idle restores the pointer, so requester 0 wins the tie
        #1 rst = 1'b1;
        last_srv = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        do_round(1'b1, 1'b1, 22'h000005, 22'h000009, 1'b0, 22'h0, 1'b1, -1);

        // Stale sample: grant lands right before a ready pulse
        do_round(1'b0, 1'b1, 22'h3AAAAA, 22'h3AAAAA, 1'b0, 22'h0, 1'b1, -1);
        do_round(1'b1, 1'b0, 22'h000155, 22'h0, 1'b0, 22'h0, 1'b1, 3);
        // Ready pulse in the grant cycle itself is not counted
        do_round(1'b0, 1'b1, 22'h0, 22'h000777, 1'b0, 22'h0, 1'b1, 4);

        // Timeout
        do_round(1'b1, 1'b0, 22'h002468, 22'h0, 1'b0, 22'h0, 1'b0, -1);
        reader_en = 1'b1;

        // Reset in CAPTURE abandons the transaction
        #1;
        addr0 = 22'h00ABCD;
        req0  = 1'b1;
        @(negedge clk);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            #1;
            n++;
            if (fl_ready) break;
        end
        repeat (2) @(negedge clk);
        #1;
        rst  = 1'b1;
        req0 = 1'b0;
        last_srv = 1'b1;
        exp_q.delete();
        saw_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack0 || ack1) saw_ack = 1'b1;
        end
        check("midrst_no_ack", {31'd0, saw_ack}, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        check("midrst_rdata", {16'd0, rdata}, 32'd0);
        check("midrst_fl_addr", {10'd0, fl_addr}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        do_round(1'b0, 1'b1, 22'h0, 22'h01F00F, 1'b0, 22'h0, 1'b1, -1);

        // Randomized rounds
        for (int r = 0; r < 30; r++) begin
            pat = $urandom_range(0, 2);
            ra0 = 22'($urandom);
            ra1 = 22'($urandom);
            rr  = 22'($urandom);
            rep = (pat != 2) && ($urandom_range(0, 3) == 0);
            en  = (pat == 2) || ($urandom_range(0, 5) != 0);
            do_round(pat != 1, pat != 0, ra0, ra1, rep, rr, en, -1);
            reader_en = 1'b1;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
